// File: rtl/change_sequencer.sv
// change_sequencer: pays out BCD change as quarters, dimes and nickels over a coin_valid/coin_ack handshake.
// Optional macro COIN_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on coin_ack while a coin is requested.
module change_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change,
  input  logic       coin_ack,
  output logic       coin_valid,
  output logic [2:0] coin_type,
  output logic [7:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    SELECT  = 3'd2,
    REQ     = 3'd3,
    RELEASE = 3'd4,
    FINISH  = 3'd5,
    FAULT   = 3'd6
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] change_r;
  logic [4:0] count_r, count_s;
  logic       coin_valid_r, coin_valid_s;
  logic [2:0] coin_type_r, coin_type_s;
  logic [7:0] remaining_r, remaining_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       error_r, error_s;
  logic       timeout_s;

  function automatic logic bcd_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && ((b[3:0] == 4'd0) || (b[3:0] == 4'd5));
  endfunction

  // Nickel count is twice the tens digit plus one for a trailing 5.
  function automatic logic [4:0] to_nickels(input logic [7:0] b);
    return {b[7:4], 1'b0} + {4'd0, (b[3:0] == 4'd5)};
  endfunction

  function automatic logic [7:0] to_bcd(input logic [4:0] n);
    return {n[4:1], (n[0] ? 4'd5 : 4'd0)};
  endfunction

  function automatic logic [2:0] pick_coin(input logic [4:0] n);
    if (n >= 5'd5) begin
      return 3'd4;
    end else if (n >= 5'd2) begin
      return 3'd2;
    end else begin
      return 3'd1;
    end
  endfunction

  function automatic logic [4:0] coin_nickels(input logic [2:0] t);
    case (t)
      3'd4:    return 5'd5;
      3'd2:    return 5'd2;
      3'd1:    return 5'd1;
      default: return 5'd0;
    endcase
  endfunction

`ifdef COIN_TIMEOUT_EN
  logic [15:0] timer_r;

  // Watchdog counts cycles spent in REQ; zero on every entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r <= 16'd0;
    end else if (state_r != REQ) begin
      timer_r <= 16'd0;
    end else begin
      timer_r <= timer_r + 16'd1;
    end
  end

  assign timeout_s = (state_r == REQ) && (timer_r == (TIMEOUT_CYCLES - 16'd1));
`else
  // No watchdog: REQ waits for coin_ack indefinitely.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES != 16'd0);
`endif

  // State, captured request and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      change_r     <= 8'h00;
      count_r      <= 5'd0;
      coin_valid_r <= 1'b0;
      coin_type_r  <= 3'd0;
      remaining_r  <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      change_r     <= ((state_r == IDLE) && start) ? change : change_r;
      count_r      <= count_s;
      coin_valid_r <= coin_valid_s;
      coin_type_r  <= coin_type_s;
      remaining_r  <= remaining_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? CHECK : IDLE;
      CHECK:   state_s = bcd_ok(change_r) ? SELECT : FAULT;
      SELECT:  state_s = (count_r == 5'd0) ? FINISH : REQ;
      REQ: begin
        if (coin_ack) begin
          state_s = RELEASE;
        end else if (timeout_s) begin
          state_s = FAULT;
        end else begin
          state_s = REQ;
        end
      end
      RELEASE: state_s = coin_ack ? RELEASE : SELECT;
      FINISH:  state_s = IDLE;
      FAULT:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values for the count and all outputs, keyed on the state being entered.
  always_comb begin
    count_s = count_r;
    case (state_r)
      CHECK:   count_s = to_nickels(change_r);
      REQ:     count_s = coin_ack ? (count_r - coin_nickels(coin_type_r)) : count_r;
      default: count_s = count_r;
    endcase
    count_s = ((state_s == FAULT) || (state_s == IDLE)) ? 5'd0 : count_s;

    coin_valid_s = (state_s == REQ);
    if (state_s == REQ) begin
      coin_type_s = (state_r == SELECT) ? pick_coin(count_r) : coin_type_r;
    end else begin
      coin_type_s = 3'd0;
    end
    remaining_s = to_bcd(count_s);
    busy_s      = (state_s != IDLE);
    done_s      = (state_s == FINISH);
    error_s     = (state_s == FAULT);
  end

  assign coin_valid = coin_valid_r;
  assign coin_type  = coin_type_r;
  assign remaining  = remaining_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_change_sequencer.sv
// Self-checking bench for change_sequencer: randomized hopper handshake and change values
// checked cycle by cycle against a coin-list model derived from the cents owed.
`timescale 1ns/1ps
module tb_change_sequencer;

  localparam logic [15:0] TO_C = 16'd8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] change;
  logic       coin_ack;
  logic       coin_valid;
  logic [2:0] coin_type;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       error;

  int total = 0;
  int bad   = 0;

  change_sequencer #(.TIMEOUT_CYCLES(TO_C)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .change     (change),
    .coin_ack   (coin_ack),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cents owed, greedy coin list, validity of the request.
  int m_coins[$];
  int m_rem     = 0;
  bit m_valid   = 1'b0;
  bit m_timeout = 1'b0;

  task automatic model_load(input logic [7:0] ch);
    int c;
    m_valid = (ch[7:4] <= 4'd9) && ((ch[3:0] == 4'd0) || (ch[3:0] == 4'd5));
    m_coins.delete();
    c = int'(ch[7:4]) * 10 + int'(ch[3:0]);
    m_rem = m_valid ? c : 0;
    if (m_valid) begin
      while (c >= 25) begin m_coins.push_back(25); c -= 25; end
      while (c >= 10) begin m_coins.push_back(10); c -= 10; end
      while (c >= 5)  begin m_coins.push_back(5);  c -= 5;  end
    end
  endtask

  function automatic logic [7:0] cents_bcd(input int c);
    return {4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [2:0] onehot(input int v);
    return (v == 25) ? 3'd4 : ((v == 10) ? 3'd2 : 3'd1);
  endfunction

  // Hopper: acks each coin after 0..3 cycles, releases 0..3 cycles after coin_valid drops.
  bit hop_mute = 1'b0;
  int ack_wait = 0;
  int rel_wait = 0;
  initial begin
    coin_ack = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (hop_mute) begin
        coin_ack = 1'b0; ack_wait = 0; rel_wait = 0;
      end else if (!coin_ack) begin
        if (coin_valid) begin
          if (ack_wait == 0) begin coin_ack = 1'b1; rel_wait = $urandom_range(0, 3); end
          else ack_wait--;
        end
      end else if (!coin_valid) begin
        if (rel_wait == 0) begin coin_ack = 1'b0; ack_wait = $urandom_range(0, 3); end
        else rel_wait--;
      end
    end
  end

  // Compare process: checks DUT outputs against the model on every falling edge.
  bit         chk_en = 1'b0;
  int         cyc = 0, start_cyc = 0, rise_cyc = 0;
  bit         m_active = 1'b0, m_end = 1'b0, prev_cv = 1'b0;
  logic [2:0] prev_type = 3'd0;
  int         done_cnt = 0, err_cnt = 0;
  logic [2:0] obs_types[$];
  logic [7:0] obs_rems[$];

  always @(negedge clock) begin
    if (!chk_en) begin
      m_active = 1'b0; m_end = 1'b0; prev_cv = 1'b0;
    end else begin
      cyc++;
      if (m_end) begin m_active = 1'b0; m_end = 1'b0; end
      chk("done_error_exclusive", {31'd0, done & error}, 32'd0);
      if (!m_active) begin
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_coin_valid", {31'd0, coin_valid}, 32'd0);
        chk("idle_remaining", {24'd0, remaining}, 32'd0);
        chk("idle_pulses", {30'd0, done, error}, 32'd0);
        if (start) begin
          m_active = 1'b1; start_cyc = cyc; model_load(change);
        end
      end else begin
        chk("busy", {31'd0, busy}, 32'd1);
        if ((cyc == start_cyc + 2) && !m_valid) chk("error_latency", {31'd0, error}, 32'd1);
        if ((cyc == start_cyc + 3) && m_valid) begin
          if (m_coins.size() == 0) chk("done_latency", {31'd0, done}, 32'd1);
          else                     chk("coin_latency", {31'd0, coin_valid}, 32'd1);
        end
        if (!m_valid) chk("no_coin_on_reject", {31'd0, coin_valid}, 32'd0);
        if (coin_valid && !prev_cv) begin
          rise_cyc = cyc;
          chk("coin_expected", {31'd0, (m_coins.size() > 0)}, 32'd1);
          if (m_coins.size() > 0) chk("coin_type", {29'd0, coin_type}, {29'd0, onehot(m_coins[0])});
          chk("remaining_at_coin", {24'd0, remaining}, {24'd0, cents_bcd(m_rem)});
          obs_types.push_back(coin_type);
        end else if (coin_valid) begin
          chk("coin_type_stable", {29'd0, coin_type}, {29'd0, prev_type});
        end
        if (!coin_valid && prev_cv && !error) begin
          if (m_coins.size() > 0) m_rem -= m_coins.pop_front();
          chk("remaining_after_coin", {24'd0, remaining}, {24'd0, cents_bcd(m_rem)});
          obs_rems.push_back(remaining);
        end
        if (done) begin
          done_cnt++;
          chk("done_expected", {31'd0, (m_valid && (m_coins.size() == 0) && !m_timeout)}, 32'd1);
          chk("remaining_at_done", {24'd0, remaining}, 32'd0);
          m_end = 1'b1;
        end
        if (error) begin
          err_cnt++;
          chk("error_expected", {31'd0, (!m_valid || m_timeout)}, 32'd1);
          if (m_timeout) chk("timeout_latency", cyc - rise_cyc, {16'd0, TO_C});
          chk("remaining_at_error", {24'd0, remaining}, 32'd0);
          chk("coin_valid_at_error", {31'd0, coin_valid}, 32'd0);
          m_end = 1'b1;
        end
      end
      prev_cv = coin_valid;
      prev_type = coin_type;
    end
  end

  task automatic run_txn(input logic [7:0] v);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int n = 0;
    obs_types.delete();
    obs_rems.delete();
    @(posedge clock); #1;
    start = 1'b1; change = v;
    @(posedge clock); #1;
    start = 1'b0; change = 8'($urandom);
    while ((done_cnt == d0) && (err_cnt == e0) && (n < 400)) begin
      @(posedge clock); #1; n++;
    end
    chk("txn_completes", {31'd0, (n < 400)}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, n;
    logic [7:0] v;
    reset = 1'b0; start = 1'b0; change = 8'h00;

    // Model pinned against hand-computed greedy results.
    model_load(8'h95);
    chk("model_95_count", m_coins.size(), 32'd5);
    chk("model_95_first", m_coins[0], 32'd25);
    chk("model_95_last", m_coins[4], 32'd10);
    chk("model_95_rem", m_rem, 32'd95);
    model_load(8'h20);
    chk("model_20", {m_coins.size(), m_coins[0], m_coins[1]}, {32'd2, 32'd10, 32'd10});
    model_load(8'h12);
    chk("model_12_reject", {31'd0, m_valid}, 32'd0);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_coin_valid", {31'd0, coin_valid}, 32'd0);
    chk("reset_coin_type", {29'd0, coin_type}, 32'd0);
    chk("reset_remaining", {24'd0, remaining}, 32'd0);
    chk("reset_flags", {29'd0, busy, done, error}, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk_en = 1'b1;

    d0 = done_cnt; run_txn(8'h20);
    chk("t20_done", done_cnt - d0, 32'd1);
    chk("t20_coins", obs_types.size(), 32'd2);
    if (obs_types.size() == 2) chk("t20_types", {26'd0, obs_types[0], obs_types[1]}, {26'd0, 3'd2, 3'd2});
    if (obs_rems.size() == 2) chk("t20_rems", {16'd0, obs_rems[0], obs_rems[1]}, 32'h0000_1000);

    d0 = done_cnt; run_txn(8'h35);
    chk("t35_done", done_cnt - d0, 32'd1);
    chk("t35_coins", obs_types.size(), 32'd2);
    if (obs_types.size() == 2) chk("t35_types", {26'd0, obs_types[0], obs_types[1]}, {26'd0, 3'd4, 3'd2});
    if (obs_rems.size() == 2) chk("t35_rems", {16'd0, obs_rems[0], obs_rems[1]}, 32'h0000_1000);

    e0 = err_cnt; run_txn(8'h12);
    chk("t12_error", err_cnt - e0, 32'd1);
    chk("t12_no_coin", obs_types.size(), 32'd0);
    e0 = err_cnt; run_txn(8'hA0);
    chk("tA0_error", err_cnt - e0, 32'd1);
    chk("tA0_no_coin", obs_types.size(), 32'd0);
    d0 = done_cnt; run_txn(8'h00);
    chk("t00_done", done_cnt - d0, 32'd1);
    chk("t00_no_coin", obs_types.size(), 32'd0);

    // Reset while a coin is outstanding: outputs must clear without a clock edge.
    chk_en = 1'b0; hop_mute = 1'b1;
    @(posedge clock); #1;
    start = 1'b1; change = 8'h15;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!coin_valid && (n < 10)) begin @(posedge clock); #1; n++; end
    chk("mid_reset_coin_up", {31'd0, coin_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_coin_valid", {31'd0, coin_valid}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    chk("mid_reset_remaining", {24'd0, remaining}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1; hop_mute = 1'b0;
    @(posedge clock); #1;
    chk_en = 1'b1;
    d0 = done_cnt; run_txn(8'h15);
    chk("after_reset_done", done_cnt - d0, 32'd1);
    if (obs_types.size() == 2) chk("after_reset_types", {26'd0, obs_types[0], obs_types[1]}, {26'd0, 3'd2, 3'd1});
    else chk("after_reset_coins", obs_types.size(), 32'd2);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) v = {4'($urandom_range(0, 9)), ($urandom_range(0, 1) == 1) ? 4'd5 : 4'd0};
      else v = 8'($urandom);
      run_txn(v);
    end
    run_txn(8'h95);

`ifdef COIN_TIMEOUT_EN
    hop_mute = 1'b1; m_timeout = 1'b1;
    e0 = err_cnt; run_txn(8'h05);
    chk("timeout_error", err_cnt - e0, 32'd1);
    chk("timeout_idle", {30'd0, coin_valid, busy}, 32'd0);
    m_timeout = 1'b0; hop_mute = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
